// File: rtl/prbs_checker.sv
// prbs_checker: serial receive-side checker for the x^16+x^15+x^13+x^4+1
// Fibonacci LFSR pattern. Seeds its shift register from the incoming stream,
// verifies LOCK_CNT further bits, then free-runs and counts bit errors.
// Optional build macro PRBS_CHK_BITCNT_EN adds a 32-bit count of bits
// checked while locked (bit_cnt).
module prbs_checker #(
  parameter int unsigned NBITS    = 16,
  parameter int unsigned LOCK_CNT = 32,
  parameter int unsigned LOSS_CNT = 8,
  parameter int unsigned ECNTW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ECNTW-1:0] err_cnt,
  output logic             lost_lock
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t           r_state, w_state_next;
  logic [NBITS-1:0] r_s, w_s_next;
  logic [4:0]       r_seed_cnt, w_seed_cnt_next;
  logic [7:0]       r_match_cnt, w_match_cnt_next;
  logic [7:0]       r_miss_cnt, w_miss_cnt_next;
  logic             w_pred;
  logic             w_err;
  logic             w_loss;
  logic             r_err_pulse;
  logic [ECNTW-1:0] r_err_cnt;
  logic             r_lost_lock;

  // Taps are fixed at bits 16,15,13,4 (1-based), so NBITS must be 16.
  assign w_pred = r_s[15] ^ r_s[14] ^ r_s[12] ^ r_s[3];

  // Next-state, shift register and counter updates; only valid bits advance.
  always_comb begin
    w_state_next     = r_state;
    w_s_next         = r_s;
    w_seed_cnt_next  = r_seed_cnt;
    w_match_cnt_next = r_match_cnt;
    w_miss_cnt_next  = r_miss_cnt;
    w_err            = 1'b0;
    w_loss           = 1'b0;
    if (din_valid) begin
      unique case (r_state)
        SEED: begin
          w_s_next = {r_s[NBITS-2:0], din};
          if (r_seed_cnt == 5'(NBITS - 1)) begin
            // All-zero seed would lock up the LFSR: restart collection.
            w_seed_cnt_next = '0;
            if (w_s_next != '0) begin
              w_state_next     = VERIFY;
              w_match_cnt_next = '0;
            end
          end else begin
            w_seed_cnt_next = r_seed_cnt + 5'd1;
          end
        end
        VERIFY: begin
          w_s_next = {r_s[NBITS-2:0], din};
          if (din == w_pred) begin
            if (r_match_cnt == 8'(LOCK_CNT - 1)) begin
              w_state_next     = LOCKED;
              w_match_cnt_next = '0;
              w_miss_cnt_next  = '0;
            end else begin
              w_match_cnt_next = r_match_cnt + 8'd1;
            end
          end else begin
            w_state_next     = SEED;
            w_seed_cnt_next  = '0;
            w_match_cnt_next = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so received errors never enter s.
          w_s_next = {r_s[NBITS-2:0], w_pred};
          if (din != w_pred) begin
            w_err = 1'b1;
            if (r_miss_cnt == 8'(LOSS_CNT - 1)) begin
              w_loss          = 1'b1;
              w_state_next    = SEED;
              w_miss_cnt_next = '0;
              w_seed_cnt_next = '0;
            end else begin
              w_miss_cnt_next = r_miss_cnt + 8'd1;
            end
          end else begin
            w_miss_cnt_next = '0;
          end
        end
        default: begin
          w_state_next    = SEED;
          w_seed_cnt_next = '0;
        end
      endcase
    end
  end

  // State, shift register and sync counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEED;
      r_s         <= '0;
      r_seed_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_s         <= w_s_next;
      r_seed_cnt  <= w_seed_cnt_next;
      r_match_cnt <= w_match_cnt_next;
      r_miss_cnt  <= w_miss_cnt_next;
    end
  end

  // Error reporting: pulse, saturating count (clear wins), sticky loss (set wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_lost_lock <= 1'b0;
    end else begin
      r_err_pulse <= w_err;
      if (clr_cnt)
        r_err_cnt <= '0;
      else if (w_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
      if (w_loss)
        r_lost_lock <= 1'b1;
      else if (clr_cnt)
        r_lost_lock <= 1'b0;
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] r_bit_cnt;

  // Saturating count of valid bits checked while locked; survives loss of lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_bit_cnt <= '0;
    else if (clr_cnt)
      r_bit_cnt <= '0;
    else if (din_valid && (r_state == LOCKED) && (r_bit_cnt != '1))
      r_bit_cnt <= r_bit_cnt + 32'd1;
  end

  assign bit_cnt = r_bit_cnt;
`endif

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign lost_lock = r_lost_lock;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed self-checking bench for prbs_checker.
// Uses a narrow error counter so saturation is reachable in a short run.
module tb_prbs_checker;
  localparam int unsigned ECNTW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             din_valid;
  logic             din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [ECNTW-1:0] err_cnt;
  logic             lost_lock;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]      bit_cnt;
`endif

  int unsigned n_checks  = 0;
  int unsigned n_fail    = 0;
  int unsigned pulse_cnt = 0;
  logic [15:0] gen;

  prbs_checker #(
    .NBITS   (16),
    .LOCK_CNT(32),
    .LOSS_CNT(8),
    .ECNTW   (ECNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din_valid(din_valid),
    .din      (din),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .lost_lock(lost_lock)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_cnt  (bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference generator: emit fb and shift it into the low end.
  task automatic gen_bit(output logic b);
    b   = gen[15] ^ gen[14] ^ gen[12] ^ gen[3];
    gen = {gen[14:0], b};
  endtask

  // One clock cycle of stimulus; outputs are sampled 1 ns after the edge.
  task automatic push(input logic v, input logic b, input logic clr = 1'b0);
    din_valid = v;
    din       = b;
    clr_cnt   = clr;
    @(posedge clk);
    #1;
    if (err_pulse) pulse_cnt++;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  task automatic send_gen(input int unsigned n, input logic inv);
    logic b;
    for (int unsigned i = 0; i < n; i++) begin
      gen_bit(b);
      push(1'b1, b ^ inv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic b;
    int unsigned nv;
    int unsigned lk_seen;

    rst = 1'b0; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    gen = 16'hACE1;
    #12;
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_err_pulse", 32'(err_pulse), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_lost_lock", 32'(lost_lock), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // Clean lock: 16 seed + 32 verify bits.
    send_gen(47, 1'b0);
    check_eq("lock_47", 32'(locked), 32'd0);
    send_gen(1, 1'b0);
    check_eq("lock_48", 32'(locked), 32'd1);
    pulse_cnt = 0;
    send_gen(1000, 1'b0);
    check_eq("clean_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("clean_pulses", pulse_cnt, 32'd0);
    check_eq("clean_locked", 32'(locked), 32'd1);
`ifdef PRBS_CHK_BITCNT_EN
    check_eq("bitcnt_1000", bit_cnt, 32'd1000);
`endif

    // Three isolated bit errors.
    pulse_cnt = 0;
    for (int unsigned i = 1; i <= 400; i++) begin
      gen_bit(b);
      push(1'b1, b ^ ((i == 100) || (i == 200) || (i == 300)));
      if (i == 100) check_eq("inj_pulse", 32'(err_pulse), 32'd1);
      if (i == 101) check_eq("inj_no_prop", 32'(err_pulse), 32'd0);
    end
    check_eq("inj_pulses", pulse_cnt, 32'd3);
    check_eq("inj_err_cnt", 32'(err_cnt), 32'd3);
    check_eq("inj_locked", 32'(locked), 32'd1);

    // Clear on an idle cycle, then lose lock with 8 inverted bits.
    push(1'b0, 1'b0, 1'b1);
    check_eq("clr_err_cnt", 32'(err_cnt), 32'd0);
`ifdef PRBS_CHK_BITCNT_EN
    check_eq("clr_bitcnt", bit_cnt, 32'd0);
`endif
    send_gen(7, 1'b1);
    check_eq("loss_7_locked", 32'(locked), 32'd1);
    check_eq("loss_7_lost", 32'(lost_lock), 32'd0);
    send_gen(1, 1'b1);
    check_eq("loss_8_locked", 32'(locked), 32'd0);
    check_eq("loss_8_lost", 32'(lost_lock), 32'd1);
    check_eq("loss_8_err_cnt", 32'(err_cnt), 32'd8);
    send_gen(47, 1'b0);
    check_eq("relock_47", 32'(locked), 32'd0);
    send_gen(1, 1'b0);
    check_eq("relock_48", 32'(locked), 32'd1);
    check_eq("relock_lost_sticky", 32'(lost_lock), 32'd1);
    check_eq("relock_err_cnt", 32'(err_cnt), 32'd8);
`ifdef PRBS_CHK_BITCNT_EN
    check_eq("loss_bitcnt_kept", bit_cnt, 32'd8);
`endif
    push(1'b0, 1'b0, 1'b1);
    check_eq("clr_lost_lock", 32'(lost_lock), 32'd0);
    check_eq("clr_err_cnt2", 32'(err_cnt), 32'd0);

    // Saturation: 20 isolated errors into a 4-bit counter.
    for (int unsigned i = 0; i < 20; i++) begin
      gen_bit(b);
      push(1'b1, ~b);
      gen_bit(b);
      push(1'b1, b);
    end
    check_eq("sat_err_cnt", 32'(err_cnt), 32'd15);
    check_eq("sat_locked", 32'(locked), 32'd1);

    // Clear coinciding with an error: clear wins on the count.
    gen_bit(b);
    push(1'b1, ~b, 1'b1);
    check_eq("clr_with_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("clr_with_err_pulse", 32'(err_pulse), 32'd1);
    send_gen(1, 1'b0);

    // Asynchronous reset mid-LOCKED, between clock edges.
    gen_bit(b);
    push(1'b1, ~b);
    check_eq("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("pre_rst_locked", 32'(locked), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_locked", 32'(locked), 32'd0);
    check_eq("arst_err_pulse", 32'(err_pulse), 32'd0);
    check_eq("arst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("arst_lost_lock", 32'(lost_lock), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // All-zero stream never locks; seeding restarts cleanly afterwards.
    lk_seen = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      push(1'b1, 1'b0);
      if (locked) lk_seen++;
    end
    check_eq("zero_never_locked", lk_seen, 32'd0);
    gen = 16'h1234;
    send_gen(47, 1'b0);
    check_eq("zero_then_47", 32'(locked), 32'd0);
    send_gen(1, 1'b0);
    check_eq("zero_then_48", 32'(locked), 32'd1);

    // 30% valid duty: lock timing counts valid bits only.
    do_reset();
    gen = 16'hBEEF;
    nv = 0;
    for (int c = 0; c < 5000 && nv < 48; c++) begin
      if ($urandom_range(99) < 30) begin
        gen_bit(b);
        push(1'b1, b);
        nv++;
        if (nv == 47) check_eq("gap_47", 32'(locked), 32'd0);
      end else begin
        push(1'b0, 1'b0);
        if (nv == 47) check_eq("gap_idle_47", 32'(locked), 32'd0);
        check_eq("gap_idle_pulse", 32'(err_pulse), 32'd0);
      end
    end
    check_eq("gap_budget", nv, 32'd48);
    check_eq("gap_48", 32'(locked), 32'd1);
    push(1'b0, 1'b0);
    push(1'b0, 1'b0);
    check_eq("gap_hold_locked", 32'(locked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial receive-side checker for the 16-bit Fibonacci LFSR pattern, polynomial x^16+x^15+x^13+x^4+1.
- Self-synchronises to an incoming bit stream, declares lock, then counts bit errors against its own free-running prediction.
- Sits at the far end of a link or loopback, opposite the LFSR generator, for bit-error-rate measurement.

Parameters:
- NBITS, 16, LFSR length; taps fixed at bits 16,15,13,4 (1-based), so only 16 is legal.
- LOCK_CNT, 32, consecutive matching bits in VERIFY required to declare lock (1..255).
- LOSS_CNT, 8, consecutive mismatches in LOCKED that force resync (1..255).
- ECNTW, 16, width of the error counter.

Ports:
- clk, input, 1, clock; all logic on posedge.
- rst, input, 1, asynchronous active-low reset.
- din_valid, input, 1, din carries a stream bit this cycle.
- din, input, 1, received stream bit.
- clr_cnt, input, 1, synchronous clear of err_cnt and sticky flags.
- locked, output, 1, checker is in LOCKED.
- err_pulse, output, 1, one-cycle pulse per mismatched bit while LOCKED.
- err_cnt, output, ECNTW, saturating count of errors seen while LOCKED.
- lost_lock, output, 1, sticky; set on LOCKED->SEED transition.

Behaviour:
- Reset and interface: rst is asynchronous, active-low; clock is clk. Reset acts immediately, including mid-operation.
- Reset values:
  - state=SEED, shift reg s=0, counters=0.
  - locked=0, err_pulse=0, err_cnt=0, lost_lock=0.
- Prediction: p = s[15]^s[14]^s[12]^s[3] (0-based). Generator shifts s<={s[14:0],fb} and emits fb.
- Only cycles with din_valid=1 advance state, s or counters. Idle cycles hold everything; err_pulse is 0 on idle cycles.
- SEED:
  - Each valid bit gives s<={s[14:0],din}; seed count increments.
  - After 16 valid bits, go to VERIFY with match count 0.
  - If s is all zeros at that point, clear the seed count and stay in SEED. All-zero is a lock-up state.
- VERIFY:
  - Each valid bit gives s<={s[14:0],din}.
  - din==p increments match count. Reaching LOCK_CNT goes to LOCKED.
  - A mismatch returns to SEED with counts cleared; s is retained but re-collected.
- LOCKED:
  - s<={s[14:0],p}: the checker free-runs, so received errors do not corrupt the prediction.
  - din!=p: err_pulse=1 next cycle; err_cnt increments, saturating at all-ones; the consecutive-miss counter increments.
  - din==p: the consecutive-miss counter clears.
  - Miss counter reaching LOSS_CNT: go to SEED, set lost_lock, locked=0 next cycle. The error that triggered the loss is still counted.
- Latency: locked, err_pulse and err_cnt are registered and update the cycle after the qualifying valid bit.
- clr_cnt:
  - Clears err_cnt and lost_lock. State and lock are unaffected.
  - If an error is counted in the same cycle, clear wins and err_cnt=0.
  - If a loss event happens in the same cycle, lost_lock=1 (set wins over clear).
- Bit-order convention: the first received bit lands in s[0] and ends in s[15] after 16 bits, matching the generator's shift direction.

Optional Feature:
- Macro: PRBS_CHK_BITCNT_EN.
- When defined:
  - Adds output bit_cnt [31:0], a saturating count of valid bits checked while LOCKED.
  - Cleared by clr_cnt and by reset.
  - Not cleared on loss of lock.
- When undefined: no bit_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Clean lock: feed generator output from seed 16'hACE1, continuous valid. locked rises after exactly 16+32=48 valid bits (next cycle); err_cnt stays 0 for 1000 further bits.
- Error injection: once locked, flip 3 isolated bits at positions 100, 200 and 300. Exactly 3 err_pulses, err_cnt=3, locked stays 1, and no error propagation into later bits.
- Loss of lock: once locked, invert 8 consecutive bits. locked drops after the 8th, lost_lock=1, err_cnt=8. With a clean stream, relock 48 bits later.
- Zero stream: feed 64 zeros. locked never asserts; state remains SEED.
- Gaps and clear:
  - Random din_valid duty of 30%: lock timing counts valid bits only.
  - clr_cnt together with an error: err_cnt=0.
  - Async rst asserted mid-LOCKED: all outputs 0 immediately.
- PRBS_CHK_BITCNT_EN: bit_cnt equals the number of valid bits checked while LOCKED (e.g. 500). clr_cnt zeroes it; loss of lock keeps its value.
